// File: rtl/ram189_bus_master.sv
// ram189_bus_master
//   Synchronous initiator for a single SN74x189 16x4 asynchronous RAM.
//   It accepts read and write requests from the core on a valid/ready
//   channel. It then sequences the RAM pins through programmable setup,
//   pulse, hold and access phases. The result goes back on a valid/ready
//   response channel: true-polarity read data for a read, or an ack for a
//   write. Only one operation is ever outstanding.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_addr,        request: 1=write / 0=read, address,
//   req_wdata                write data (true polarity)
//   rsp_valid/rsp_ready      response handshake
//   rsp_we, rsp_rdata        echo of request type, read data (0 for writes)
//   ram_a, ram_d             RAM address / data-in pins
//   ram_cs_, ram_we_         RAM chip select / write enable (active-low)
//   ram_o_                   RAM outputs (inverted data), only used in R_ACCESS
//
// State table
//   IDLE     | ready for a request; RAM deselected
//   W_SETUP  | cs_ low, addr/data stable, we_ still high
//   W_PULSE  | we_ low, write in progress
//   W_HOLD   | we_ back high, addr/data/cs_ held
//   R_ACCESS | cs_ low, waiting out the RAM access time
//   RESP     | response presented, waiting for rsp_ready

module ram189_bus_master #(
    parameter int AW         = 4,
    parameter int DW         = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int ACCESS_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_cs_,
    output logic          ram_we_,
    input  logic [DW-1:0] ram_o_
);

    generate
        if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || ACCESS_CYC < 1) begin : g_param_err
            $error("ram189_bus_master: all phase lengths must be >= 1");
        end
    endgenerate

    localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CD  = (HOLD_CYC > ACCESS_CYC) ? HOLD_CYC : ACCESS_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // The counter holds "cycles remaining minus one", so the phase ends on the edge where it reads 0.
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] ACCESS_LD = CW'(ACCESS_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_PULSE  = 3'd2,
        W_HOLD   = 3'd3,
        R_ACCESS = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_we_q,    rsp_we_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0] ram_a_q,     ram_a_d;
    logic [DW-1:0] ram_d_q,     ram_d_d;
    logic          ram_cs_q,    ram_cs_d;
    logic          ram_we_q,    ram_we_d;

    logic cnt_done;
    assign cnt_done = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        ram_cs_d    = ram_cs_q;
        ram_we_d    = ram_we_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    // Address and data are captured only here.
                    // They therefore stay still for the whole write strobe.
                    ram_a_d     = req_addr;
                    ram_d_d     = req_wdata;
                    ram_cs_d    = 1'b0;
                    req_ready_d = 1'b0;
                    if (req_we) begin
                        state_d = W_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = R_ACCESS;
                        cnt_d   = ACCESS_LD;
                    end
                end
            end
            W_SETUP: begin
                if (cnt_done) begin
                    state_d  = W_PULSE;
                    ram_we_d = 1'b0;
                    cnt_d    = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            W_PULSE: begin
                if (cnt_done) begin
                    state_d  = W_HOLD;
                    ram_we_d = 1'b1;
                    cnt_d    = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            W_HOLD: begin
                if (cnt_done) begin
                    state_d     = RESP;
                    ram_cs_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            R_ACCESS: begin
                if (cnt_done) begin
                    state_d     = RESP;
                    ram_cs_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b0;
                    rsp_rdata_d = ~ram_o_;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                ram_cs_d    = 1'b1;
                ram_we_d    = 1'b1;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            ram_cs_q    <= 1'b1;
            ram_we_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_d     = ram_d_q;
    assign ram_cs_   = ram_cs_q;
    assign ram_we_   = ram_we_q;

endmodule

// File: tb/tb_ram189_bus_master.sv
// Testbench for ram189_bus_master.
// It includes a behavioural 74x189 model and a scoreboard memory of
// expected contents. A pin monitor flags any address/data movement while
// the write strobe is low, any write strobe outside chip select, and any
// we_ falling in the same cycle as cs_.

module tb_ram189_bus_master;

    localparam int SETUP  = 1;
    localparam int PULSE  = 2;
    localparam int HOLD   = 1;
    localparam int ACCESS = 2;
    localparam int WLAT   = SETUP + PULSE + HOLD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = '0;
    logic [3:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_we;
    logic [3:0] rsp_rdata;
    logic [3:0] ram_a;
    logic [3:0] ram_d;
    logic       ram_cs_;
    logic       ram_we_;
    logic [3:0] ram_o_;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    always #5 clk = ~clk;

    ram189_bus_master #(
        .AW(4), .DW(4),
        .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD), .ACCESS_CYC(ACCESS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .ram_a(ram_a), .ram_d(ram_d), .ram_cs_(ram_cs_), .ram_we_(ram_we_), .ram_o_(ram_o_)
    );

    // 74x189 model: it writes while cs_ and we_ are both low, and drives inverted data when reading.
    logic [3:0] ram_mem [16];
    always @(ram_cs_, ram_we_, ram_a, ram_d)
        if (!ram_cs_ && !ram_we_) ram_mem[ram_a] = ram_d;
    assign ram_o_ = (!ram_cs_ && ram_we_) ? ~ram_mem[ram_a] : 4'hF;

    // Scoreboard memory: the expected RAM contents after each acknowledged write.
    logic [3:0] ref_mem   [16];
    bit         ref_known [16];

    // Pin protocol monitor
    logic       prev_we, prev_cs;
    logic [3:0] prev_a, prev_d;
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b1; prev_cs = 1'b1; prev_a = '0; prev_d = '0;
        end else begin
            if (!prev_we && (ram_a !== prev_a || ram_d !== prev_d)) viol++;
            if (prev_cs && !ram_cs_ && !ram_we_) viol++;
            if (!ram_we_ && ram_cs_) viol++;
            prev_we = ram_we_; prev_cs = ram_cs_; prev_a = ram_a; prev_d = ram_d;
        end
    end

    // Per-cycle pin trace of the current operation.
    // Index 0 is the cycle right after the acceptance edge.
    logic       tr_cs [64];
    logic       tr_we [64];
    logic [3:0] tr_a  [64];
    logic [3:0] tr_d  [64];

    task automatic issue(input logic we, input logic [3:0] a, input logic [3:0] d, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            ok = 1'b0;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(input int delay, output int lat, output logic [3:0] rdata,
                           output logic rwe, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        rsp_ready = (delay == 0);
        while (1) begin
            @(negedge clk);
            tr_cs[n] = ram_cs_; tr_we[n] = ram_we_; tr_a[n] = ram_a; tr_d[n] = ram_d;
            if (rsp_valid) break;
            if (n >= 60) begin
                ok = 1'b0;
                break;
            end
            @(posedge clk);
            n++;
        end
        lat = n; rdata = rsp_rdata; rwe = rsp_we;
        if (!ok) begin
            rsp_ready = 1'b1;
            return;
        end
        repeat (delay) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit ok;
        // Reset values while the power-on reset is still asserted.
        n_cmp++; if (ram_cs_ !== 1'b1 || ram_we_ !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL por_outputs: cs_=%b we_=%b req_ready=%b rsp_valid=%b want 1 1 1 0",
                              ram_cs_, ram_we_, req_ready, rsp_valid); end
        @(negedge clk); rst = 1'b0;
        // Start a read. Then assert reset in the middle of a clock, while cs_ is low.
        issue(1'b0, 4'h5, 4'h9, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_issue: accept timeout"); end
        #2;
        n_cmp++; if (ram_cs_ !== 1'b0) begin n_err++; $display("FAIL rst_pre_cs: cs_=%b want 0", ram_cs_); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ram_cs_ !== 1'b1) begin n_err++; $display("FAIL rst_cs: got %b want 1", ram_cs_); end
        n_cmp++; if (ram_we_ !== 1'b1) begin n_err++; $display("FAIL rst_we: got %b want 1", ram_we_); end
        n_cmp++; if (ram_a !== 4'h0) begin n_err++; $display("FAIL rst_a: got %h want 0", ram_a); end
        n_cmp++; if (ram_d !== 4'h0) begin n_err++; $display("FAIL rst_d: got %h want 0", ram_d); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_we !== 1'b0) begin n_err++; $display("FAIL rst_rsp_we: got %b want 0", rsp_we); end
        n_cmp++; if (rsp_rdata !== 4'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_release: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_write();
        logic [3:0] wa [2];
        logic [3:0] wd [2];
        bit ok, aok;
        int lat, wlow, first_low;
        logic [3:0] rd;
        logic rwe;
        bit cs_ok, ad_ok;
        wa[0] = 4'h0; wd[0] = 4'h5; wa[1] = 4'h1; wd[1] = 4'hA;
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, wa[k], wd[k], aok);
            collect(0, lat, rd, rwe, ok);
            n_cmp++; if (!aok || !ok) begin n_err++; $display("FAIL wr%0d_timeout: accept=%0d rsp=%0d want 1 1", k, aok, ok); continue; end
            ref_mem[wa[k]] = wd[k]; ref_known[wa[k]] = 1'b1;
            n_cmp++; if (lat != WLAT) begin n_err++; $display("FAIL wr%0d_latency: got %0d want %0d", k, lat, WLAT); end
            n_cmp++; if (rwe !== 1'b1 || rd !== 4'h0) begin n_err++; $display("FAIL wr%0d_ack: rsp_we=%b rdata=%h want 1 0", k, rwe, rd); end
            wlow = 0; first_low = -1; cs_ok = 1'b1; ad_ok = 1'b1;
            for (int i = 0; i < lat; i++) begin
                if (tr_we[i] === 1'b0) begin wlow++; if (first_low < 0) first_low = i; end
                if (tr_cs[i] !== 1'b0) cs_ok = 1'b0;
                if (tr_a[i] !== wa[k] || tr_d[i] !== wd[k]) ad_ok = 1'b0;
            end
            n_cmp++; if (wlow != PULSE) begin n_err++; $display("FAIL wr%0d_pulse_len: got %0d want %0d", k, wlow, PULSE); end
            n_cmp++; if (first_low != SETUP) begin n_err++; $display("FAIL wr%0d_pulse_start: got %0d want %0d", k, first_low, SETUP); end
            n_cmp++; if (!cs_ok || tr_cs[lat] !== 1'b1) begin n_err++; $display("FAIL wr%0d_cs_window: held=%0d end=%b want 1 1", k, cs_ok, tr_cs[lat]); end
            n_cmp++; if (!ad_ok) begin n_err++; $display("FAIL wr%0d_ad_stable: got changed want stable", k); end
        end
    endtask

    task automatic test_read();
        logic [3:0] ra [2];
        logic [3:0] want [2];
        bit ok, aok;
        int lat;
        logic [3:0] rd;
        logic rwe;
        ra[0] = 4'h1; want[0] = 4'hA; ra[1] = 4'h0; want[1] = 4'h5;
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, ra[k], 4'h0, aok);
            collect(0, lat, rd, rwe, ok);
            n_cmp++; if (!aok || !ok) begin n_err++; $display("FAIL rd%0d_timeout: accept=%0d rsp=%0d want 1 1", k, aok, ok); continue; end
            n_cmp++; if (rd !== want[k]) begin n_err++; $display("FAIL rd%0d_data: got %h want %h", k, rd, want[k]); end
            n_cmp++; if (lat != ACCESS) begin n_err++; $display("FAIL rd%0d_latency: got %0d want %0d", k, lat, ACCESS); end
            n_cmp++; if (rwe !== 1'b0) begin n_err++; $display("FAIL rd%0d_rsp_we: got %b want 0", k, rwe); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, aok;
        int n, lat;
        logic [3:0] rd;
        logic rwe;
        issue(1'b0, 4'h1, 4'h0, aok);
        rsp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        n_cmp++; if (!aok || !rsp_valid) begin
            n_err++; $display("FAIL bp_timeout: accept=%0d rsp_valid=%b want 1 1", aok, rsp_valid);
            rsp_ready = 1'b1; return;
        end
        // Offer a second request while the response is stalled. The master must not take it.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h0; req_wdata = 4'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[1]) begin
                n_err++; $display("FAIL bp_hold%0d: rsp_valid=%b rdata=%h want 1 %h", c, rsp_valid, rsp_rdata, ref_mem[1]); end
            n_cmp++; if (req_ready !== 1'b0 || ram_cs_ !== 1'b1) begin
                n_err++; $display("FAIL bp_ignore%0d: req_ready=%b cs_=%b want 0 1", c, req_ready, ram_cs_); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready); end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0 || ram_cs_ !== 1'b0 || ram_a !== 4'h0) begin
            n_err++; $display("FAIL bp_accept: req_ready=%b cs_=%b a=%h want 0 0 0", req_ready, ram_cs_, ram_a); end
        req_valid = 1'b0;
        collect(0, lat, rd, rwe, ok);
        n_cmp++; if (!ok || rd !== ref_mem[0] || rwe !== 1'b0) begin
            n_err++; $display("FAIL bp_second_rd: ok=%0d rdata=%h rsp_we=%b want 1 %h 0", ok, rd, rwe, ref_mem[0]); end
    endtask

    task automatic test_fill();
        bit ok, aok;
        int lat, bad;
        logic [3:0] rd, v;
        logic rwe;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i) ^ 4'hF;
            issue(1'b1, 4'(i), v, aok);
            collect(0, lat, rd, rwe, ok);
            if (aok && ok) begin ref_mem[i] = v; ref_known[i] = 1'b1; end
            else bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL fill_writes: got %0d timeouts want 0", bad); end
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 4'(i), 4'h0, aok);
            collect(0, lat, rd, rwe, ok);
            n_cmp++; if (!aok || !ok || rd !== (4'(i) ^ 4'hF)) begin
                n_err++; $display("FAIL fill_rd_%0d: got %h want %h", i, rd, 4'(i) ^ 4'hF); end
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL pin_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_random();
        bit ok, aok, we;
        int lat, dly;
        logic [3:0] a, d, rd;
        logic rwe;
        for (int k = 0; k < 40; k++) begin
            we  = 1'($urandom_range(0, 1));
            a   = 4'($urandom_range(0, 15));
            d   = 4'($urandom_range(0, 15));
            dly = $urandom_range(0, 3);
            issue(we, a, d, aok);
            collect(dly, lat, rd, rwe, ok);
            n_cmp++; if (!aok || !ok) begin n_err++; $display("FAIL rnd%0d_timeout: accept=%0d rsp=%0d", k, aok, ok); continue; end
            n_cmp++; if (lat != (we ? WLAT : ACCESS) || rwe !== we) begin
                n_err++; $display("FAIL rnd%0d_lat_we: lat=%0d rsp_we=%b want %0d %b", k, lat, rwe, we ? WLAT : ACCESS, we); end
            if (we) begin
                ref_mem[a] = d; ref_known[a] = 1'b1;
            end else if (ref_known[a]) begin
                n_cmp++; if (rd !== ref_mem[a]) begin n_err++; $display("FAIL rnd%0d_rdata a=%h: got %h want %h", k, a, rd, ref_mem[a]); end
            end
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL rnd_pin_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_mid_write();
        bit ok, aok;
        int lat;
        logic [3:0] rd, prior2;
        logic rwe;
        prior2 = ref_mem[2];
        issue(1'b1, 4'h3, 4'hC, aok);
        repeat (SETUP) @(posedge clk);
        #3;
        n_cmp++; if (!aok || ram_we_ !== 1'b0) begin n_err++; $display("FAIL rw_in_pulse: accept=%0d we_=%b want 1 0", aok, ram_we_); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ram_we_ !== 1'b1 || ram_cs_ !== 1'b1) begin
            n_err++; $display("FAIL rw_strobe_off: we_=%b cs_=%b want 1 1", ram_we_, ram_cs_); end
        ref_known[3] = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_err++; $display("FAIL rw_no_rsp%0d: rsp_valid=%b req_ready=%b want 0 1", c, rsp_valid, req_ready); end
        end
        issue(1'b0, 4'h2, 4'h0, aok);
        collect(0, lat, rd, rwe, ok);
        n_cmp++; if (!aok || !ok || rd !== prior2) begin
            n_err++; $display("FAIL rw_neighbour: got %h want %h", rd, prior2); end
    endtask

    initial begin
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 4'($urandom_range(0, 15));
            ram_mem[i] = v; ref_mem[i] = v; ref_known[i] = 1'b1;
        end
        #12;
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_fill();
        test_random();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_err=%0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
